// File: rtl/time_bcd_converter_pkg.sv
// -----------------------------------------------------------------------------
// time_bcd_converter_pkg
// Purpose : Shared definitions for the binary-to-BCD time converter.
//           Holds the BCD digit width, the controller state encoding, the
//           default millisecond clamp value and the double-dabble add-3 helper.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package time_bcd_converter_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int MS_MAX_DEFAULT = 999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Double-dabble correction: a digit of 5 or more would become 10 or more
    // after the next left shift, so it is pre-biased by 3 to carry correctly.
    function automatic logic [BCD_DIGIT_W-1:0] add3(input logic [BCD_DIGIT_W-1:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/time_bcd_converter_core.sv
// -----------------------------------------------------------------------------
// bcd_dd_core
// Purpose : One iterative double-dabble converter. load_i captures a binary
//           value and performs its first shift; every step_i cycle after that
//           shifts one more bit until BIN_W bits are consumed, then the result
//           is held until the next load.
// Ports   : clk_i    - system clock
//           reset_i  - synchronous, active-high reset
//           load_i   - capture bin_i and start a new conversion
//           step_i   - advance the conversion by one bit
//           bin_i    - binary value, must be below 10**DIGITS
//           bcd_o    - packed BCD digits, most significant digit on top
//           done_o   - all BIN_W bits have been shifted in
// -----------------------------------------------------------------------------
module bcd_dd_core
    import time_bcd_converter_pkg::*;
#(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            load_i,
    input  logic                            step_i,
    input  logic [BIN_W-1:0]                bin_i,
    output logic [DIGITS*BCD_DIGIT_W-1:0]   bcd_o,
    output logic                            done_o
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int LOW_W = (DIGITS - 1) * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BIN_W);

    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic [LOW_W-1:0] w_adjLow;
    logic [BCD_W-1:0] w_next;

    // Apply the add-3 correction to every digit except the top one. Because
    // the input is always below 10**DIGITS, the top digit is at most 4 before
    // any shift, so it never needs correcting and its MSB is always zero.
    always_comb begin
        w_adjLow = '0;
        for (int d = 0; d < DIGITS - 1; d++) begin
            w_adjLow[d*BCD_DIGIT_W +: BCD_DIGIT_W] = add3(r_bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    // Shift the corrected digits left by one, pulling in the next binary MSB.
    assign w_next = {r_bcd[BCD_W-2 -: BCD_DIGIT_W-1], w_adjLow, r_bin[BIN_W-1]};

    // Load seeds the digit register with the first input bit so the whole
    // conversion fits inside the controller's fixed run length; steps stop
    // once the count reaches BIN_W so narrower fields simply hold early.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (load_i) begin
            r_bcd <= BCD_W'(bin_i[BIN_W-1]);
            r_bin <= {bin_i[BIN_W-2:0], 1'b0};
            r_cnt <= CNT_W'(1);
        end else if (step_i && !done_o) begin
            r_bcd <= w_next;
            r_bin <= {r_bin[BIN_W-2:0], 1'b0};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bcd_o  = r_bcd;
    assign done_o = (r_cnt == CNT_FULL);

endmodule

// File: rtl/time_bcd_converter.sv
// -----------------------------------------------------------------------------
// time_bcd_converter
// Purpose : Converts the selected binary time fields into BCD digits for the
//           VGA digit renderer. Four double-dabble cores run in parallel; the
//           visible digit registers update only on completion so the renderer
//           never sees a half-converted value.
// Ports   : clk_i, reset_i          - clock, synchronous active-high reset
//           start_i                 - conversion request (level, sampled each clk)
//           hour_i/min_i/sec_i      - binary hour/minute/second
//           ms_i                    - binary milliseconds, clamped to MS_MAX
//           hour/min/sec_bcd_o      - {tens,ones}
//           ms_bcd_o                - {hundreds,tens,ones}
//           busy_o                  - conversion in progress
//           valid_o                 - one-cycle pulse when the digits update
//           range_err_o             - last accepted ms_i exceeded MS_MAX
// -----------------------------------------------------------------------------
module time_bcd_converter
    import time_bcd_converter_pkg::*;
#(
    parameter int HR_W   = 6,
    parameter int MN_W   = 6,
    parameter int SC_W   = 6,
    parameter int MS_W   = 10,
    parameter int MS_MAX = MS_MAX_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic [HR_W-1:0] hour_i,
    input  logic [MN_W-1:0] min_i,
    input  logic [SC_W-1:0] sec_i,
    input  logic [MS_W-1:0] ms_i,
    output logic [7:0]      hour_bcd_o,
    output logic [7:0]      min_bcd_o,
    output logic [7:0]      sec_bcd_o,
    output logic [11:0]     ms_bcd_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic            range_err_o
);

    localparam int CNT_W = $clog2(MS_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MS_W - 1);
    localparam logic [MS_W-1:0]  MS_CLAMP = MS_W'(MS_MAX);

    state_t          r_state;
    logic [CNT_W-1:0] r_shiftCnt;
    logic            r_pending;
    logic            r_busy;
    logic            r_valid;
    logic            r_rangeErr;
    logic [7:0]      r_hourBcd;
    logic [7:0]      r_minBcd;
    logic [7:0]      r_secBcd;
    logic [11:0]     r_msBcd;

    logic            w_msOver;
    logic [MS_W-1:0] w_msClamped;
    logic            w_accept;
    logic            w_step;
    logic [7:0]      w_hourBcd;
    logic [7:0]      w_minBcd;
    logic [7:0]      w_secBcd;
    logic [11:0]     w_msBcd;
    logic            w_hourDone;
    logic            w_minDone;
    logic            w_secDone;
    logic            w_msDone;
    logic            w_allDone;

    // Milliseconds above MS_MAX are pinned to MS_MAX so the three-digit core
    // never sees a value it cannot represent.
    assign w_msOver    = (ms_i > MS_CLAMP);
    assign w_msClamped = w_msOver ? MS_CLAMP : ms_i;

    // A new capture happens from IDLE on start, or straight out of DONE when a
    // request arrived during the run or arrives in the DONE cycle itself.
    assign w_accept = ((r_state == ST_IDLE) && start_i) ||
                      ((r_state == ST_DONE) && (start_i || r_pending));
    assign w_step   = (r_state == ST_CONV);
    assign w_allDone = w_hourDone && w_minDone && w_secDone && w_msDone;

    bcd_dd_core #(.BIN_W(HR_W), .DIGITS(2)) u_hourCore (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(w_accept), .step_i(w_step),
        .bin_i(hour_i), .bcd_o(w_hourBcd), .done_o(w_hourDone)
    );

    bcd_dd_core #(.BIN_W(MN_W), .DIGITS(2)) u_minCore (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(w_accept), .step_i(w_step),
        .bin_i(min_i), .bcd_o(w_minBcd), .done_o(w_minDone)
    );

    bcd_dd_core #(.BIN_W(SC_W), .DIGITS(2)) u_secCore (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(w_accept), .step_i(w_step),
        .bin_i(sec_i), .bcd_o(w_secBcd), .done_o(w_secDone)
    );

    bcd_dd_core #(.BIN_W(MS_W), .DIGITS(3)) u_msCore (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(w_accept), .step_i(w_step),
        .bin_i(w_msClamped), .bcd_o(w_msBcd), .done_o(w_msDone)
    );

    // Controller: IDLE -> CONV for MS_W cycles -> DONE (one cycle) -> IDLE.
    // The cores take their first shift on the capture edge, so by the last
    // CONV cycle every core has finished and the digit registers can load on
    // that edge, making valid_o appear MS_W+1 cycles after the accepted start.
    // A start seen while converting is remembered once in r_pending.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_shiftCnt <= '0;
            r_pending  <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_rangeErr <= 1'b0;
            r_hourBcd  <= '0;
            r_minBcd   <= '0;
            r_secBcd   <= '0;
            r_msBcd    <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_state    <= ST_CONV;
                r_shiftCnt <= '0;
                r_busy     <= 1'b1;
                r_pending  <= 1'b0;
                r_rangeErr <= w_msOver;
            end else begin
                case (r_state)
                    ST_CONV: begin
                        if (start_i) begin
                            r_pending <= 1'b1;
                        end
                        if ((r_shiftCnt == CNT_LAST) && w_allDone) begin
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_valid   <= 1'b1;
                            r_hourBcd <= w_hourBcd;
                            r_minBcd  <= w_minBcd;
                            r_secBcd  <= w_secBcd;
                            r_msBcd   <= w_msBcd;
                        end else begin
                            r_shiftCnt <= r_shiftCnt + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign hour_bcd_o  = r_hourBcd;
    assign min_bcd_o   = r_minBcd;
    assign sec_bcd_o   = r_secBcd;
    assign ms_bcd_o    = r_msBcd;
    assign busy_o      = r_busy;
    assign valid_o     = r_valid;
    assign range_err_o = r_rangeErr;

endmodule

// File: tb/tb_time_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_time_bcd_converter
// Purpose : Self-checking bench for time_bcd_converter. Stimulus pushes the
//           expected digits, error flag and arrival cycle of each conversion
//           into a queue; an independent monitor pops and compares on valid_o.
// -----------------------------------------------------------------------------
module tb_time_bcd_converter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [5:0]  hour_i;
    logic [5:0]  min_i;
    logic [5:0]  sec_i;
    logic [9:0]  ms_i;
    logic [7:0]  hour_bcd_o;
    logic [7:0]  min_bcd_o;
    logic [7:0]  sec_bcd_o;
    logic [11:0] ms_bcd_o;
    logic        busy_o;
    logic        valid_o;
    logic        range_err_o;

    typedef struct {
        logic [7:0]  hour;
        logic [7:0]  minute;
        logic [7:0]  sec;
        logic [11:0] ms;
        logic        err;
        int          cycle;
    } exp_t;

    exp_t sbQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    time_bcd_converter dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i), .ms_i(ms_i),
        .hour_bcd_o(hour_bcd_o), .min_bcd_o(min_bcd_o), .sec_bcd_o(sec_bcd_o),
        .ms_bcd_o(ms_bcd_o), .busy_o(busy_o), .valid_o(valid_o),
        .range_err_o(range_err_o)
    );

    // 10-time-unit clock; cyc numbers the interval following each rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: counts it and reports a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer division, independent of double-dabble.
    function automatic logic [7:0] ref2(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [11:0] ref3(input int v);
        int c;
        c = (v > 999) ? 999 : v;
        return 12'(((c / 100) << 8) | (((c / 10) % 10) << 4) | (c % 10));
    endfunction

    // Drive one start pulse in the current cycle; when doCheck is set, queue
    // the expected result to arrive 'latency' cycles from now.
    task automatic applyStimulus(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                                 input logic [9:0] ms, input bit doCheck,
                                 input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                                 input logic [11:0] ems, input logic eErr, input int latency);
        exp_t e;
        hour_i  = h;
        min_i   = m;
        sec_i   = s;
        ms_i    = ms;
        start_i = 1'b1;
        if (doCheck) begin
            e.hour   = eh;
            e.minute = em;
            e.sec    = es;
            e.ms     = ems;
            e.err    = eErr;
            e.cycle  = cyc + latency;
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Bounded wait for every queued result; an expired budget is a failure.
    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    // Monitor: every valid_o pulse must match the oldest queued expectation,
    // including the cycle it arrives in; a pulse with nothing queued is an error.
    always @(negedge clk) begin
        exp_t e;
        if (valid_o === 1'b1) begin
            if (sbQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_valid: valid_o=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sbQ.pop_front();
                checkOutput("hour_bcd", 32'(hour_bcd_o), 32'(e.hour));
                checkOutput("min_bcd", 32'(min_bcd_o), 32'(e.minute));
                checkOutput("sec_bcd", 32'(sec_bcd_o), 32'(e.sec));
                checkOutput("ms_bcd", 32'(ms_bcd_o), 32'(e.ms));
                checkOutput("range_err", 32'(range_err_o), 32'(e.err));
                checkOutput("valid_cycle", 32'(cyc), 32'(e.cycle));
                checkOutput("busy_at_valid", 32'(busy_o), 32'd0);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a reference-model sweep.
    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        hour_i  = '0;
        min_i   = '0;
        sec_i   = '0;
        ms_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Idle after reset: everything stays at zero, no valid pulse.
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_hour", 32'(hour_bcd_o), 32'h0);
        checkOutput("reset_min", 32'(min_bcd_o), 32'h0);
        checkOutput("reset_sec", 32'(sec_bcd_o), 32'h0);
        checkOutput("reset_ms", 32'(ms_bcd_o), 32'h0);
        checkOutput("reset_busy", 32'(busy_o), 32'h0);
        checkOutput("reset_valid", 32'(valid_o), 32'h0);
        checkOutput("reset_range_err", 32'(range_err_o), 32'h0);
        @(posedge clk);
        #1;

        // 23:59:07.999 with busy window N+1..N+10 and valid at N+11.
        applyStimulus(6'd23, 6'd59, 6'd7, 10'd999, 1'b1, 8'h23, 8'h59, 8'h07, 12'h999, 1'b0, 11);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checkOutput("busy_during_conv", 32'(busy_o), 32'h1);
        end
        @(negedge clk);
        checkOutput("busy_in_done", 32'(busy_o), 32'h0);
        waitDrain(30);

        // Clamp of an out-of-range millisecond value and sticky error flag.
        applyStimulus(6'd12, 6'd34, 6'd56, 10'd1023, 1'b1, 8'h12, 8'h34, 8'h56, 12'h999, 1'b1, 11);
        waitDrain(30);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("range_err_sticky", 32'(range_err_o), 32'h1);
        checkOutput("ms_hold", 32'(ms_bcd_o), 32'h999);
        @(posedge clk);
        #1;
        applyStimulus(6'd0, 6'd0, 6'd0, 10'd0, 1'b1, 8'h00, 8'h00, 8'h00, 12'h000, 1'b0, 11);
        waitDrain(30);

        // Boundaries: literal 60..63 and the first value past the clamp.
        applyStimulus(6'd63, 6'd60, 6'd9, 10'd1000, 1'b1, 8'h63, 8'h60, 8'h09, 12'h999, 1'b1, 11);
        waitDrain(30);
        applyStimulus(6'd10, 6'd1, 6'd50, 10'd100, 1'b1, 8'h10, 8'h01, 8'h50, 12'h100, 1'b0, 11);
        waitDrain(30);

        // Start at N, pending start at N+4 (valid N+22), third at N+15 (valid N+33).
        applyStimulus(6'd1, 6'd2, 6'd3, 10'd4, 1'b1, 8'h01, 8'h02, 8'h03, 12'h004, 1'b0, 11);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(6'd45, 6'd6, 6'd38, 10'd512, 1'b1, 8'h45, 8'h06, 8'h38, 12'h512, 1'b0, 18);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(6'd9, 6'd19, 6'd29, 10'd1001, 1'b1, 8'h09, 8'h19, 8'h29, 12'h999, 1'b1, 18);
        waitDrain(60);
        repeat (15) @(posedge clk);
        @(negedge clk);
        checkOutput("busy_after_chain", 32'(busy_o), 32'h0);
        @(posedge clk);
        #1;

        // Reset at N+5 aborts the run; start at N+8 completes at N+19.
        applyStimulus(6'd7, 6'd7, 6'd7, 10'd1023, 1'b0, 8'h00, 8'h00, 8'h00, 12'h000, 1'b0, 11);
        repeat (4) @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        checkOutput("abort_hour", 32'(hour_bcd_o), 32'h0);
        checkOutput("abort_min", 32'(min_bcd_o), 32'h0);
        checkOutput("abort_sec", 32'(sec_bcd_o), 32'h0);
        checkOutput("abort_ms", 32'(ms_bcd_o), 32'h0);
        checkOutput("abort_busy", 32'(busy_o), 32'h0);
        checkOutput("abort_range_err", 32'(range_err_o), 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        applyStimulus(6'd22, 6'd33, 6'd44, 10'd555, 1'b1, 8'h22, 8'h33, 8'h44, 12'h555, 1'b0, 11);
        waitDrain(30);

        // Sweep against the integer-division reference model.
        for (int k = 0; k < 1000; k++) begin
            int h;
            int m;
            int s;
            int ms;
            h  = int'($urandom_range(0, 63));
            m  = int'($urandom_range(0, 63));
            s  = int'($urandom_range(0, 63));
            ms = int'($urandom_range(0, 1023));
            applyStimulus(6'(h), 6'(m), 6'(s), 10'(ms), 1'b1,
                          ref2(h), ref2(m), ref2(s), ref3(ms), (ms > 999), 11);
            waitDrain(30);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
